pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, flush and bubble insertion. It generalises the fixed 64-bit enable-only fetch register into a width-configurable stage that sits between any two RISC-V pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It gives single-cycle latency and full throughput, and accepts no new data while it is full. On flush or reset the stage outputs a configurable NOP bubble.

---
 rtl/pipe_stage_skid.sv | 108 ++++++++++
 tb/tb_pipe_stage_skid.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and NOP bubble.
// Define PIPE_STAGE_PERF_EN to add the saturating downstream back-pressure counter (stall_cnt).
module pipe_stage_skid #(
    parameter int                 WIDTH     = 64,
    parameter logic [WIDTH-1:0]   NOP_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             accept, take;

    assign accept   = in_valid & in_ready;
    assign take     = out_valid & out_ready;
    assign out_data = main_q;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    main_nxt  = in_data;
                end
            end
            ST_ONE: begin
                if (accept && take) begin
                    main_nxt = in_data;
                end else if (accept) begin
                    state_nxt = ST_FULL;
                    skid_nxt  = in_data;
                end else if (take) begin
                    state_nxt = ST_EMPTY;
                    main_nxt  = NOP_VALUE;
                end
            end
            ST_FULL: begin
                if (take) begin
                    state_nxt = ST_ONE;
                    main_nxt  = skid_q;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
                main_nxt  = NOP_VALUE;
            end
        endcase
        // Flush overrides everything; handshakes still complete but accepted data is dropped.
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_nxt  = NOP_VALUE;
        end
    end

    // Handshake flags are registered from the next state so outputs come straight from flops.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            main_q    <= NOP_VALUE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            main_q    <= main_nxt;
            in_ready  <= (state_nxt != ST_FULL);
            out_valid <= (state_nxt != ST_EMPTY);
        end
    end

    // NOTE: skid is a pure data register, only meaningful in FULL, so it is deliberately left unreset.
    always_ff @(posedge clk) begin
        skid_q <= skid_nxt;
    end

`ifdef PIPE_STAGE_PERF_EN
    // Counts cycles where a valid head is blocked downstream; cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table plus FIFO scoreboard model.
// Honours PIPE_STAGE_PERF_EN to exercise the stall counter when it is built in.
module tb_pipe_stage_skid;

    localparam int          W   = 64;
    localparam logic [63:0] NOP = 64'h0000_0013_0000_0013;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of held entries plus expected stall count.
    logic [63:0] q[$];
    logic [31:0] m_cnt = 32'd0;

    typedef struct {
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        fl;
        logic        rs;
        logic        e_ir;
        logic        e_ov;
        logic [63:0] e_od;
    } vec_t;

    vec_t vecs[20];

    function automatic logic [63:0] pi(input logic [31:0] pc, input logic [31:0] inst);
        return {pc, inst};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, compare against model before the edge, advance model, sample after edge.
    task automatic cycle(input logic iv, input logic [63:0] d, input logic ordy,
                         input logic fl, input logic rs);
        logic acc, tk;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        acc = iv && (q.size() < 2);
        tk  = ordy && (q.size() > 0);
        if (!rs) begin
            check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
            check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            check("out_data", out_data, (q.size() > 0) ? q[0] : NOP);
        end
        @(posedge clk);
        if (rs) m_cnt = 32'd0;
        else if ((q.size() > 0) && !ordy && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
        if (rs || fl) begin
            q.delete();
        end else begin
            if (tk) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        #1;
`ifdef PIPE_STAGE_PERF_EN
        check("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_cnt});
`endif
    endtask

    initial begin
        logic [63:0] a, b, c, dd, e;
        a  = pi(32'h0, 32'h10);
        b  = pi(32'h4, 32'h20);
        c  = pi(32'h8, 32'h30);
        dd = pi(32'hC, 32'h40);
        e  = pi(32'h100, 32'h55);

        //            iv  data ordy fl rs  ir  ov  od
        vecs[0]  = '{1'b1, a,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, a};   // streaming
        vecs[1]  = '{1'b1, b,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, b};
        vecs[2]  = '{1'b1, c,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, c};
        vecs[3]  = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, NOP};
        vecs[4]  = '{1'b1, a,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, a};   // back-pressure
        vecs[5]  = '{1'b1, b,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, b};
        vecs[6]  = '{1'b1, c,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, b};   // FULL: b main, c skid
        vecs[7]  = '{1'b1, dd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, b};   // dd refused
        vecs[8]  = '{1'b1, dd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, b};
        vecs[9]  = '{1'b1, dd, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, c};   // drain FULL->ONE
        vecs[10] = '{1'b1, dd, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, dd};
        vecs[11] = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, NOP};
        vecs[12] = '{1'b1, a,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a};   // flush while FULL
        vecs[13] = '{1'b1, b,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a};
        vecs[14] = '{1'b0, 0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, NOP};
        vecs[15] = '{1'b1, e,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, e};
        vecs[16] = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, NOP};
        vecs[17] = '{1'b1, a,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a};   // rst+flush priority
        vecs[18] = '{1'b1, b,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, NOP};
        vecs[19] = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, NOP};

        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; rst = 1'b1;

        // Reset for two cycles, then check the bubble.
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, NOP);
`ifdef PIPE_STAGE_PERF_EN
        check("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
        rst = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, vecs[i].rs);
            check($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].e_ir});
            check($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
            check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
`ifdef PIPE_STAGE_PERF_EN
            if (i == 18) check("prio_stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
        end

        // Perf sequence: one entry held for 5 blocked cycles, then flushed with out_ready high.
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, a, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        check("perf_flush_out_valid", {63'd0, out_valid}, 64'd0);
`ifdef PIPE_STAGE_PERF_EN
        check("perf_cnt_after_flush", {32'd0, stall_cnt}, 64'd5);
`endif
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check("perf_cnt_hold", {32'd0, stall_cnt}, 64'd5);
`endif

        // Random traffic checked against the scoreboard every cycle.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), 1'b0);
        end
        // Final drain must empty the model and the DUT together.
        for (int k = 0; k < 3; k++) cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        check("drain_out_valid", {63'd0, out_valid}, 64'd0);
        check("drain_out_data", out_data, NOP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
